multi_edge_detector: RTL and testbench

- Parametrised, multi-channel edge detector for asynchronous level inputs such as switches, keys and external strobes.
- Each channel provides:
  - a configurable synchroniser;
  - a per-channel edge mode (off / rising / falling / both);
  - a registered single-cycle edge pulse;
  - a sticky pending flag with write-1-to-clear.
- A combined interrupt output summarises the enabled pending flags.
- Sits between board I/O pins and the control/CSR logic.

---
 rtl/multi_edge_detector.sv | 121 ++++++++++++
 tb/tb_multi_edge_detector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, per-channel edge mode, sticky pending and irq.
// Optional glitch filter enabled by defining MULTI_EDGE_DETECTOR_FILTER_EN.
module multi_edge_detector #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter bit          INIT_LEVEL    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  input  logic [WIDTH-1:0]   irq_mask,
  output logic [WIDTH-1:0]   level_out,
  output logic [WIDTH-1:0]   edge_pulse,
  output logic [WIDTH-1:0]   pending,
  output logic               irq
);

  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LEVEL}};

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("multi_edge_detector: SYNC_STAGES must be 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("multi_edge_detector: FILTER_CYCLES must be 1..255");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] mode_rise;
  logic [WIDTH-1:0] mode_fall;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] edge_d, edge_q;
  logic [WIDTH-1:0] pending_d, pending_q;
  logic             irq_d, irq_q;

  // Synchroniser chain; the last stage is the metastability-safe level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= INIT_VEC;
    end else begin
      sync_q[0] <= signal_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
  localparam logic [7:0] CNT_MAX = 8'(FILTER_CYCLES - 1);

  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  // A level is accepted only after it differs from filt for FILTER_CYCLES cycles in a row.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= INIT_VEC;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level_s = filt_q;
`else
  assign level_s = sync_s;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_mode
    assign mode_rise[g] = mode[2*g];
    assign mode_fall[g] = mode[2*g+1];
  end

  // Qualified edges against the previous level; mode is applied in the detection cycle.
  always_comb begin
    edge_d    = (mode_rise & level_s & ~last_q) | (mode_fall & ~level_s & last_q);
    pending_d = edge_q | (pending_q & ~clear);
    irq_d     = |(pending_d & irq_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= INIT_VEC;
      edge_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      last_q    <= level_s;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign level_out  = level_s;
  assign edge_pulse = edge_q;
  assign pending    = pending_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: history-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_multi_edge_detector;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int F    = 4;
  localparam logic [W-1:0] INIT_VEC = '0;
`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam int LAT  = S + FILT * F;
  localparam int MAXK = 4095;

  logic           clk;
  logic           reset;
  logic [W-1:0]   signal_in;
  logic [2*W-1:0] mode;
  logic [W-1:0]   clear;
  logic [W-1:0]   irq_mask;
  logic [W-1:0]   level_out;
  logic [W-1:0]   edge_pulse;
  logic [W-1:0]   pending;
  logic           irq;

  multi_edge_detector #(
    .WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .signal_in(signal_in), .mode(mode), .clear(clear),
    .irq_mask(irq_mask), .level_out(level_out), .edge_pulse(edge_pulse),
    .pending(pending), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-edge histories of the sampled input, the synchronised level,
  // the accepted level, the pulses and the pending flags.
  logic [W-1:0] in_h [0:MAXK];
  logic [W-1:0] s_h  [0:MAXK];
  logic [W-1:0] f_h  [0:MAXK];
  logic [W-1:0] l_h  [0:MAXK];
  logic [W-1:0] e_h  [0:MAXK];
  logic [W-1:0] p_h  [0:MAXK];
  int k;
  logic [W-1:0] exp_level, exp_edge, exp_pend;
  logic         exp_irq;

  function automatic logic [W-1:0] hin(input int j); return (j < 1) ? INIT_VEC : in_h[j]; endfunction
  function automatic logic [W-1:0] hs(input int j);  return (j < 1) ? INIT_VEC : s_h[j];  endfunction
  function automatic logic [W-1:0] hf(input int j);  return (j < 1) ? INIT_VEC : f_h[j];  endfunction
  function automatic logic [W-1:0] hl(input int j);  return (j < 1) ? INIT_VEC : l_h[j];  endfunction
  function automatic logic [W-1:0] he(input int j);  return (j < 1) ? '0 : e_h[j];        endfunction
  function automatic logic [W-1:0] hp(input int j);  return (j < 1) ? '0 : p_h[j];        endfunction

  logic [W-1:0] m_fprev, m_fnew, m_st, m_l1, m_l2, m_mr, m_mf;
  logic [2*W-1:0] m_mode;
  bit m_diff;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0;
      exp_level = INIT_VEC; exp_edge = '0; exp_pend = '0; exp_irq = 1'b0;
    end else if (k < MAXK) begin
      k = k + 1;
      in_h[k] = signal_in;
      s_h[k]  = hin(k - S + 1);
      // Accepted level moves to s once the last F values of s all disagree with it.
      m_fprev = hf(k - 1);
      m_fnew  = m_fprev;
      for (int c = 0; c < W; c++) begin
        m_diff = 1'b1;
        for (int t = 1; t <= F; t++) begin
          m_st = hs(k - t);
          if (m_st[c] == m_fprev[c]) m_diff = 1'b0;
        end
        if (m_diff) begin
          m_st = hs(k - 1);
          m_fnew[c] = m_st[c];
        end
      end
      f_h[k] = m_fnew;
      l_h[k] = (FILT != 0) ? f_h[k] : s_h[k];
      m_l1 = hl(k - 1);
      m_l2 = hl(k - 2);
      m_mode = mode;
      for (int c = 0; c < W; c++) begin
        m_mr[c] = m_mode[2*c];
        m_mf[c] = m_mode[2*c+1];
      end
      e_h[k] = (m_mr & m_l1 & ~m_l2) | (m_mf & ~m_l1 & m_l2);
      p_h[k] = he(k - 1) | (hp(k - 1) & ~clear);
      exp_level = l_h[k];
      exp_edge  = e_h[k];
      exp_pend  = p_h[k];
      exp_irq   = |(p_h[k] & irq_mask);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_level", level_out, exp_level);
      chk("model_edge", edge_pulse, exp_edge);
      chk("model_pending", pending, exp_pend);
      chk("model_irq", irq, exp_irq);
    end
  end

  logic [7:0] tv_in  [12] = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'hFF, 8'h00, 8'h81, 8'h00};
  int         tv_hold[12] = '{3, 7, 1, 8, 2, 9, 5, 4, 3, 6, 10, 12};
  logic [7:0] tv_clr [12] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'hC3, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};

  int npulse, p0, p1;

  initial begin
    signal_in = '0; mode = '0; clear = '0; irq_mask = '0; reset = 1'b1;
    @(negedge clk);
    run_cmp = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset release: nothing happens.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("idle_edge", edge_pulse, 0);
      chk("idle_pending", pending, 0);
      chk("idle_irq", irq, 0);
      chk("idle_level", level_out, 0);
    end

    // Rising-only channel 0.
    mode = 16'h0001; irq_mask = 8'h01;
    signal_in[0] = 1'b1;
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clk);
      chk("rise_pulse", edge_pulse[0], (j == LAT));
      chk("rise_pending", pending[0], (j >= LAT + 1));
      chk("rise_irq", irq, (j >= LAT + 1));
    end
    signal_in[0] = 1'b0;
    for (int j = 0; j < LAT + 3; j++) begin
      @(negedge clk);
      chk("fall_ignored", edge_pulse[0], 0);
    end

    // Both-edge channel 3, 5-cycle high pulse.
    mode = 16'h00C1;
    npulse = 0; p0 = -1; p1 = -1;
    for (int j = 0; j < 20; j++) begin
      signal_in[3] = (j < 5);
      @(negedge clk);
      if (edge_pulse[3]) begin
        npulse++;
        if (p0 < 0) p0 = j; else p1 = j;
      end
    end
    chk("both_count", npulse, 2);
    chk("both_first", p0, LAT);
    chk("both_second", p1, LAT + 5);

    // Same stimulus with channel 3 off.
    mode = 16'h0001;
    npulse = 0;
    for (int j = 0; j < 20; j++) begin
      signal_in[3] = (j < 5);
      @(negedge clk);
      if (edge_pulse[3]) npulse++;
    end
    chk("off_count", npulse, 0);
    chk("off_pending_kept", pending[3], 1);

    // Clear coinciding with a new pulse: set wins; clear alone then drops it.
    mode = 16'h0003;
    chk("pre_clear_pending", pending[0], 1);
    signal_in[0] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("clr_pulse_now", edge_pulse[0], 1);
    clear[0] = 1'b1;
    @(negedge clk);
    chk("clr_set_wins", pending[0], 1);
    @(negedge clk);
    chk("clr_alone", pending[0], 0);
    chk("clr_irq_drop", irq, 0);
    clear[0] = 1'b0;

    // Short glitch on channel 1, then a held level.
    mode = 16'h000C;
    signal_in[0] = 1'b0;
    npulse = 0;
    for (int j = 0; j < 20; j++) begin
      signal_in[1] = (j < 3);
      @(negedge clk);
      if (edge_pulse[1]) npulse++;
    end
    chk("glitch_count", npulse, (FILT != 0) ? 0 : 2);
    signal_in[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("held_pulse", edge_pulse[1], (j == LAT));
    end

    // Mixed vectors on all channels; the model checks every cycle.
    mode = 16'hE4E4; irq_mask = 8'hAA;
    for (int v = 0; v < 12; v++) begin
      signal_in = tv_in[v];
      clear = tv_clr[v];
      repeat (tv_hold[v]) @(negedge clk);
    end

    // All channels pending, then asynchronous reset between clock edges.
    mode = 16'hFFFF; irq_mask = 8'hFF; clear = '0;
    signal_in = 8'hFF;
    repeat (LAT + 3) @(negedge clk);
    chk("all_pending", pending, 8'hFF);
    chk("all_irq", irq, 1);
    signal_in = 8'h00;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_level", level_out, 0);
    chk("async_edge", edge_pulse, 0);
    chk("async_pending", pending, 0);
    chk("async_irq", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    signal_in = 8'hFF;
    npulse = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (edge_pulse[0]) npulse++;
      if (j == LAT) chk("post_reset_all", edge_pulse, 8'hFF);
    end
    chk("post_reset_once", npulse, 1);

    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
